// File: rtl/button_event_fsm_pkg.sv
// Shared types and timing constants for the push-button event classifier.
package button_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        LONG   = 3'd2,
        GAP    = 3'd3,
        PRESS2 = 3'd4
    } state_e;

    localparam int unsigned ClkFreq     = 32'd100_000_000;
    localparam int unsigned LongPressMs = 32'd500;
    localparam int unsigned RepeatMs    = 32'd100;
    localparam int unsigned GapMs       = 32'd250;

    // Convert a duration in milliseconds into clk cycles at ClkFreq.
    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return ms * (ClkFreq / 32'd1000);
    endfunction

    localparam int unsigned DefLongCycles   = ms_to_cycles(LongPressMs);
    localparam int unsigned DefRepeatCycles = ms_to_cycles(RepeatMs);
    localparam int unsigned DefGapCycles    = ms_to_cycles(GapMs);

endpackage

// File: rtl/button_event_fsm_edge_detect.sv
// Registers the debounced level and flags its rising and falling edges.
module edge_detect #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic d_q_r;

    // Previous-sample register; its reset value decides whether a level held through reset looks like an edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_q_r <= ResetVal;
        end else begin
            d_q_r <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q_r;
    assign fall_o = ~d_i & d_q_r;

endmodule

// File: rtl/button_event_fsm.sv
// Classifies debounced button presses into short/double/long events plus long-press repeats.
module button_event_fsm
    import button_pkg::*;
#(
    parameter int unsigned LongCycles   = DefLongCycles,
    parameter int unsigned RepeatCycles = DefRepeatCycles,
    parameter int unsigned GapCycles    = DefGapCycles
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic db_i,
    output logic short_press_o,
    output logic double_press_o,
    output logic long_press_o,
    output logic repeat_o,
    output logic busy_o
);

    localparam int unsigned MaxLr     = (LongCycles > RepeatCycles) ? LongCycles : RepeatCycles;
    localparam int unsigned MaxCycles = (MaxLr > GapCycles) ? MaxLr : GapCycles;
    localparam int unsigned CntW      = $clog2(MaxCycles + 32'd1);

    localparam logic [CntW-1:0] LongCnt   = CntW'(LongCycles);
    localparam logic [CntW-1:0] RepeatCnt = CntW'(RepeatCycles);
    localparam logic [CntW-1:0] GapCnt    = CntW'(GapCycles);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);
    localparam logic [CntW-1:0] CntZero   = CntW'(0);

    state_e          state_r, state_s;
    logic [CntW-1:0] cnt_r, cnt_s, cnt_inc_s;
    logic            rise_s, fall_s;
    logic            short_r, double_r, long_r, repeat_r, busy_r;
    logic            short_s, double_s, long_s, repeat_s;

    edge_detect #(
        .ResetVal (1'b1)
    ) u_edge (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (db_i),
        .rise_o (rise_s),
        .fall_o (fall_s)
    );

    // The counter is reloaded on every state entry, so it never exceeds MaxCycles and cannot wrap.
    assign cnt_inc_s = cnt_r + CntOne;

    // Next-state, counter and event decode; a rise in GAP wins over the gap timeout.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        short_s  = 1'b0;
        double_s = 1'b0;
        long_s   = 1'b0;
        repeat_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    state_s = PRESS1;
                    cnt_s   = CntOne;
                end else begin
                    cnt_s = CntZero;
                end
            end
            PRESS1: begin
                if (fall_s) begin
                    state_s = GAP;
                    cnt_s   = CntOne;
                end else if (db_i) begin
                    if (cnt_inc_s == LongCnt) begin
                        long_s  = 1'b1;
                        state_s = LONG;
                        cnt_s   = CntOne;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            LONG: begin
                if (fall_s) begin
                    state_s = IDLE;
                    cnt_s   = CntZero;
                end else if (db_i) begin
                    if (cnt_r == RepeatCnt) begin
                        repeat_s = 1'b1;
                        cnt_s    = CntOne;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            GAP: begin
                if (rise_s) begin
                    state_s = PRESS2;
                    cnt_s   = CntOne;
                end else if (!db_i) begin
                    if (cnt_inc_s == GapCnt) begin
                        short_s = 1'b1;
                        state_s = IDLE;
                        cnt_s   = CntZero;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            PRESS2: begin
                if (fall_s) begin
                    double_s = 1'b1;
                    state_s  = IDLE;
                    cnt_s    = CntZero;
                end else if (db_i) begin
                    if (cnt_inc_s == LongCnt) begin
                        long_s  = 1'b1;
                        state_s = LONG;
                        cnt_s   = CntOne;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CntZero;
            end
        endcase
    end

    // State, counter and registered outputs; busy tracks the state being loaded.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= IDLE;
            cnt_r    <= CntZero;
            short_r  <= 1'b0;
            double_r <= 1'b0;
            long_r   <= 1'b0;
            repeat_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            short_r  <= short_s;
            double_r <= double_s;
            long_r   <= long_s;
            repeat_r <= repeat_s;
            busy_r   <= (state_s != IDLE);
        end
    end

    assign short_press_o  = short_r;
    assign double_press_o = double_r;
    assign long_press_o   = long_r;
    assign repeat_o       = repeat_r;
    assign busy_o         = busy_r;

endmodule
